// File: rtl/vga_sync_receiver.sv
// Recovers pixel/line position from active-low hSync/vSync sampled on a pixel strobe,
// and declares lock after LOCK_FRAMES consecutive well-formed frames.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hSync,
  input  logic       vSync,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam int         GW      = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [9:0] H_A0    = 10'(H_ACT_START);
  localparam logic [9:0] H_A1    = 10'(H_ACT_END);
  localparam logic [9:0] V_A0    = 10'(V_ACT_START);
  localparam logic [9:0] V_A1    = 10'(V_ACT_END);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

  state_e        state_q, state_d;
  logic          h_q, h_d, v_q, v_d;
  logic [9:0]    hCount_q, hCount_d, vCount_q, vCount_d;
  logic [7:0]    err_q, err_d;
  logic [GW-1:0] good_q, good_d;
  logic          hfall, vfall, frameStart, violation;

  assign hfall      = pix_en & h_q & ~hSync;
  assign vfall      = pix_en & v_q & ~vSync;
  assign frameStart = hfall & vfall;

  // A frame-start edge is only legal exactly one pixel after the last pixel of the last line.
  assign violation = (state_q != SEARCH) &&
                     ((hfall && (hCount_q != H_LAST)) ||
                      (pix_en && (hCount_q == CNT_MAX)) ||
                      (vfall && !hfall) ||
                      (hfall && !vfall && (vCount_q == V_LAST)) ||
                      (frameStart && (vCount_q != V_LAST)));

  always_comb begin
    h_d      = h_q;
    v_d      = v_q;
    hCount_d = hCount_q;
    vCount_d = vCount_q;
    if (pix_en) begin
      h_d = hSync;
      v_d = vSync;
      if (hfall) begin
        hCount_d = '0;
        vCount_d = vfall ? '0 : vCount_q + 10'd1;
      end else if (hCount_q != CNT_MAX) begin
        hCount_d = hCount_q + 10'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = err_q;
    unique case (state_q)
      SEARCH: begin
        if (frameStart) begin
          state_d = TRACK;
          good_d  = '0;
        end
      end
      TRACK: begin
        if (frameStart) begin
          good_d = good_q + GW'(1);
          if (good_d == GW'(LOCK_FRAMES)) state_d = LOCKED;
        end
      end
      LOCKED:  state_d = state_q;
      default: state_d = SEARCH;
    endcase
    // A violation outranks any frame-start seen on the same strobe.
    if (violation) begin
      state_d = SEARCH;
      good_d  = '0;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= SEARCH;
      h_q      <= 1'b1;
      v_q      <= 1'b1;
      hCount_q <= '0;
      vCount_q <= '0;
      err_q    <= '0;
      good_q   <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
      err_q    <= err_d;
      good_q   <= good_d;
    end
  end

  assign hCount    = hCount_q;
  assign vCount    = vCount_q;
  assign err_count = err_q;
  assign locked    = (state_q == LOCKED);
  assign bright    = locked && (hCount_q >= H_A0) && (hCount_q < H_A1) &&
                     (vCount_q >= V_A0) && (vCount_q < V_A1);

endmodule

// File: doc/vga_sync_receiver.md
VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 SHALL provide parameters: H_TOTAL 800, pixels per line.
REQ-002 SHALL provide parameters: V_TOTAL 525, lines per frame.
REQ-003 SHALL provide parameters: H_ACT_START 144 / H_ACT_END 784, active pixel window [start,end).
REQ-004 SHALL provide parameters: V_ACT_START 35 / V_ACT_END 515, active line window [start,end).
REQ-005 SHALL provide parameter LOCK_FRAMES 2, consecutive good frames required to lock.
REQ-006 SHALL have ports: clk  input  1  system clock (single clock domain, all logic posedge clk).
REQ-007 SHALL have ports: rst_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have ports: pix_en  input  1  one-cycle pixel strobe (1 per pixel period).
REQ-009 SHALL have ports: hSync  input  1  active-low horizontal sync from the timing source.
REQ-010 SHALL have ports: vSync  input  1  active-low vertical sync, edges coincident with hSync falling edge.
REQ-011 SHALL have ports: hCount  output  10  recovered pixel index within the line.
REQ-012 SHALL have ports: vCount  output  10  recovered line index within the frame.
REQ-013 SHALL have ports: bright  output  1  recovered active-video flag.
REQ-014 SHALL have ports: locked  output  1  timing lock indicator.
REQ-015 SHALL have ports: err_count  output  8  saturating count of timing violations.

Function
REQ-016 SHALL sample hSync/vSync into h_q/v_q only on pix_en; all state SHALL change only on pix_en cycles, except reset.
REQ-017 SHALL detect hfall = pix_en & h_q & ~hSync and vfall = pix_en & v_q & ~vSync.
REQ-018 SHALL, on hfall, load hCount to 0; otherwise, on pix_en, increment hCount and saturate at 1023.
REQ-019 SHALL, on hfall without vfall, increment vCount; on hfall with vfall, load vCount to 0.
REQ-020 SHALL make recovered hCount/vCount lag the source counters by exactly one pixel period.
REQ-021 SHALL implement FSM states SEARCH, TRACK, LOCKED; reset state is SEARCH.
REQ-022 SHALL, in SEARCH, stay until hfall&vfall, then enter TRACK with good_frames=0; no violation checking occurs in SEARCH.
REQ-023 SHALL flag a violation in TRACK or LOCKED on any of the following:
- hfall with hCount != H_TOTAL-1
- hCount reaching 1023
- vfall without hfall
- hfall without vfall while vCount == V_TOTAL-1
- hfall&vfall with vCount != V_TOTAL-1
REQ-024 SHALL, on a violation, go to SEARCH, clear good_frames, and increment err_count, which saturates at 255.
REQ-025 SHALL, in TRACK, on a good frame end (hfall&vfall, vCount==V_TOTAL-1, hCount==H_TOTAL-1), increment good_frames; reaching LOCK_FRAMES SHALL enter LOCKED.
REQ-026 SHALL drive locked=1 exactly while the state is LOCKED; it deasserts on the pix_en cycle following the violating edge.
REQ-027 SHALL define bright = locked & (H_ACT_START<=hCount<H_ACT_END) & (V_ACT_START<=vCount<V_ACT_END), decoded from the registered counts with no extra latency.
REQ-028 SHALL NOT raise a violation on the first frame-start edge that is taken in SEARCH.
REQ-029 SHALL, when a violation and a frame-start occur together, give the violation priority; SEARCH SHALL still resynchronise on a later hfall&vfall.

Reset
REQ-030 SHALL, on rst_n=0 at posedge clk, clear:
- hCount, vCount, err_count, good_frames to 0
- bright, locked to 0
- h_q, v_q to 1
- state to SEARCH
REQ-031 SHALL, if reset is asserted mid-frame, abort tracking at once; after release, behaviour SHALL be identical to power-up.

Verification
REQ-032 SHALL verify nominal lock: feed the 800x525 source, pix_en every 4th clk -> locked rises at the end of the 2nd full frame after first sync, err_count=0.
REQ-033 SHALL verify active window: when locked, with source at (144,35), one pixel later hCount=144, vCount=35, bright=1; at (784,35) -> bright=0.
REQ-034 SHALL verify short line: one line with 799 pixels while locked -> locked=0 on the next pix_en, err_count=1, relock after 2 good frames.
REQ-035 SHALL verify missing hsync: hold hSync high for 1100 pixels -> hCount saturates at 1023, err_count increments once, state SEARCH.
REQ-036 SHALL verify misplaced vsync: vSync falls at source hCount=400 -> violation, err_count+1, locked=0.
REQ-037 SHALL verify reset: assert rst_n=0 for 1 clk mid-frame while locked -> all outputs 0 next clk; err_count saturation checked with 300 injected errors -> err_count=255.
